// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, FSM state codes, decoder constants and negate helper for the divider
package div_unit_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_t;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic [5:0] EXE_DIV = 6'b011010;
  localparam logic [5:0] EXE_DIVU = 6'b011011;
  function automatic logic [WIDTH-1:0] twos(input logic [WIDTH-1:0] x, input logic n);
    return n ? (~x) + WIDTH'(1) : x;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage request/result bundle between the pipeline and the divider
interface div_unit_if;
  import div_unit_pkg::*;
  logic start_i;
  logic signed_i;
  logic annul_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic ready_o;
  logic stall_o;
  modport master(output start_i, signed_i, annul_i, opdata1_i, opdata2_i, input result_o, ready_o, stall_o);
  modport slave(input start_i, signed_i, annul_i, opdata1_i, opdata2_i, output result_o, ready_o, stall_o);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider with signed fix-up, abort and divide-by-zero handling
module div_unit
  import div_unit_pkg::*;
(
  input logic clk,
  input logic rst,
  div_unit_if.slave d
);
  div_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvs, rem, quo, rem_nx, quo_nx;
  logic [WIDTH:0] diff;
  logic neg_q, neg_r, go, s1, s2;
  assign d.stall_o = d.start_i & ~d.ready_o;
  assign go = d.start_i & ~d.annul_i;
  assign s1 = d.signed_i & d.opdata1_i[WIDTH-1];
  assign s2 = d.signed_i & d.opdata2_i[WIDTH-1];
  // diff keeps the carry bit so divisors above 2^(WIDTH-1) still compare correctly
  always_comb begin
    diff = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    rem_nx = diff[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
      cnt <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      d.ready_o <= DIV_RESULT_NOT_READY;
      d.result_o <= '0;
    end else begin
      d.ready_o <= DIV_RESULT_NOT_READY;
      case (state)
        DIV_FREE: if (go) begin
          state <= d.opdata2_i == '0 ? DIV_BYZERO : DIV_ON;
          quo <= twos(d.opdata1_i, s1);
          dvs <= twos(d.opdata2_i, s2);
          rem <= '0;
          cnt <= '0;
          neg_r <= s1;
          neg_q <= s1 ^ s2;
        end
        DIV_BYZERO: if (go) begin
          state <= DIV_END;
          d.ready_o <= DIV_RESULT_READY;
          d.result_o <= '0;
        end else state <= DIV_FREE;
        DIV_ON: if (!go) state <= DIV_FREE;
        else begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DIV_END;
            d.ready_o <= DIV_RESULT_READY;
            d.result_o <= {twos(rem_nx, neg_r), twos(quo_nx, neg_q)};
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed divides checked against an arithmetic latency/result model and literals
module tb_div_unit;
  logic clk = 1'b0;
  logic rst, start, sgn, annul;
  logic [31:0] op1, op2;
  int passed = 0, total = 0, cyc = 0;
  bit pend = 1'b0;
  int age = 0, due = 0;
  logic [63:0] exp_res = '0;
  div_unit_if dif();
  assign dif.start_i = start;
  assign dif.signed_i = sgn;
  assign dif.annul_i = annul;
  assign dif.opdata1_i = op1;
  assign dif.opdata2_i = op2;
  div_unit dut(.clk(clk), .rst(rst), .d(dif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb;
    if (b == 0) return 64'd0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Inputs only change just after posedge, so values seen here are what the next edge samples
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = pend && age == due;
    chk("ready", {63'd0, dif.ready_o}, {63'd0, exp_rdy});
    chk("stall", {63'd0, dif.stall_o}, {63'd0, start & ~exp_rdy});
    if (exp_rdy) chk("result", dif.result_o, exp_res);
    if (rst) pend = 1'b0;
    else if (pend) begin
      if (exp_rdy || annul || !start) pend = 1'b0;
      else age++;
    end else if (start && !annul) begin
      pend = 1'b1;
      age = 1;
      due = op2 == 0 ? 2 : 33;
      exp_res = model(op1, op2, sgn);
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit s, input logic [63:0] lit,
                     input int lat, input string nm, input bit keep, output int rc);
    int n;
    @(posedge clk); #2;
    start = 1'b1; sgn = s; op1 = a; op2 = b; annul = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!dif.ready_o && n < 60);
    rc = cyc;
    if (!dif.ready_o) chk({"timeout_", nm}, 64'd0, 64'd1);
    else begin
      chk({"lat_", nm}, 64'(n - 1), 64'(lat));
      chk({"lit_", nm}, dif.result_o, lit);
    end
    if (!keep) begin @(posedge clk); #2; start = 1'b0; end
  endtask

  initial begin
    int rc1, rc2, pulses;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, dif.ready_o}, 64'd0);
    chk("rst_result", dif.result_o, 64'd0);
    chk("rst_stall", {63'd0, dif.stall_o}, 64'd0);
    chk("model_pin_div_m7_2", model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("model_pin_wrap", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
    run(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7", 1'b0, rc1);
    run(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2", 1'b0, rc1);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2", 1'b0, rc1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, "div_wrap", 1'b0, rc1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 33, "divu_big", 1'b0, rc1);
    run(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, {32'h7FFF_FFFF, 32'd1}, 33, "divu_msb_dvs", 1'b0, rc1);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33, "divu_by1", 1'b0, rc1);
    run(32'd5, 32'd0, 1'b0, 64'd0, 2, "divu_5_0", 1'b0, rc1);
    run(32'hFFFF_FFFB, 32'd0, 1'b1, 64'd0, 2, "div_m5_0", 1'b0, rc1);
    // abort by annul at cycle 10, with annul still beating start in the following idle cycle
    @(posedge clk); #2;
    start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
    repeat (10) @(posedge clk);
    #2 annul = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2 start = 1'b0; annul = 1'b0;
    pulses = 0;
    repeat (40) begin @(negedge clk); pulses += int'(dif.ready_o); end
    chk("annul_no_ready", 64'(pulses), 64'd0);
    run(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "after_annul", 1'b0, rc1);
    // abort by dropping start mid-operation
    @(posedge clk); #2;
    start = 1'b1; op1 = 32'd50; op2 = 32'd6;
    repeat (5) @(posedge clk);
    #2 start = 1'b0;
    repeat (40) @(negedge clk);
    // reset during an operation
    @(posedge clk); #2;
    start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'd0, dif.ready_o}, 64'd0);
    chk("midrst_result", dif.result_o, 64'd0);
    run(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "b2b_first", 1'b1, rc1);
    run(32'd10, 32'd4, 1'b0, {32'd2, 32'd2}, 33, "b2b_second", 1'b0, rc2);
    chk("b2b_gap", 64'(rc2 - rc1), 64'd34);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
